// File: rtl/read_bus_arbiter_pkg.sv
// Shared owner IDs and address-FSM states for the read-bus arbiter.
package read_bus_arbiter_pkg;

    localparam logic ARB_OWNER_IR = 1'b0;
    localparam logic ARB_OWNER_DR = 1'b1;

    typedef enum logic {
        ARB_STATE_IDLE = 1'b0,
        ARB_STATE_ADDR = 1'b1
    } arb_state_t;

endpackage

// File: rtl/read_bus_arbiter_owner_fifo.sv
// In-order 1-bit owner FIFO: remembers which requester issued each outstanding read.
module read_bus_arbiter_owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem_q[rd_ptr];

    assign do_pop  = pop && !empty;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (do_pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/read_bus_arbiter.sv
// Round-robin merge of instruction and data read channels onto one memory read port.
module read_bus_arbiter
    import read_bus_arbiter_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ir_addr_valid,
    output logic                 ir_addr_ready,
    input  logic [BUS_WIDTH-1:0] ir_addr,
    output logic                 ir_data_valid,
    input  logic                 ir_data_ready,
    output logic [BUS_WIDTH-1:0] ir_data,
    input  logic                 dr_addr_valid,
    output logic                 dr_addr_ready,
    input  logic [BUS_WIDTH-1:0] dr_addr,
    output logic                 dr_data_valid,
    input  logic                 dr_data_ready,
    output logic [BUS_WIDTH-1:0] dr_data,
    output logic                 mem_addr_valid,
    input  logic                 mem_addr_ready,
    output logic [BUS_WIDTH-1:0] mem_addr,
    input  logic                 mem_data_valid,
    output logic                 mem_data_ready,
    input  logic [BUS_WIDTH-1:0] mem_data,
    output logic                 protocol_err
);
    arb_state_t state, state_nx;
    logic       last_grant;
    logic       grant_id;
    logic       push;
    logic       pop;
    logic       full;
    logic       empty;
    logic       head;

    always_ff @(posedge clk) begin
        if (!rst) state <= ARB_STATE_IDLE;
        else      state <= state_nx;
    end

    // Grant depends only on registered state and requester valids, never on mem_addr_ready.
    always_comb begin
        state_nx      = state;
        ir_addr_ready = 1'b0;
        dr_addr_ready = 1'b0;
        grant_id      = ARB_OWNER_IR;
        push          = 1'b0;
        case (state)
            ARB_STATE_IDLE: begin
                if (!full && (ir_addr_valid || dr_addr_valid)) begin
                    if (ir_addr_valid && dr_addr_valid)
                        grant_id = ~last_grant;
                    else
                        grant_id = dr_addr_valid ? ARB_OWNER_DR : ARB_OWNER_IR;
                    ir_addr_ready = (grant_id == ARB_OWNER_IR);
                    dr_addr_ready = (grant_id == ARB_OWNER_DR);
                    push          = 1'b1;
                    state_nx      = ARB_STATE_ADDR;
                end
            end
            ARB_STATE_ADDR: begin
                if (mem_addr_ready)
                    state_nx = ARB_STATE_IDLE;
            end
            default: state_nx = ARB_STATE_IDLE;
        endcase
    end

    assign mem_addr_valid = (state == ARB_STATE_ADDR);

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_addr   <= '0;
            last_grant <= ARB_OWNER_IR;
        end else if (push) begin
            mem_addr   <= (grant_id == ARB_OWNER_DR) ? dr_addr : ir_addr;
            last_grant <= grant_id;
        end
    end

    read_bus_arbiter_owner_fifo #(
        .DEPTH (DEPTH)
    ) u_owner_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (grant_id),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign ir_data        = mem_data;
    assign dr_data        = mem_data;
    assign ir_data_valid  = mem_data_valid && !empty && (head == ARB_OWNER_IR);
    assign dr_data_valid  = mem_data_valid && !empty && (head == ARB_OWNER_DR);
    assign mem_data_ready = !empty && ((head == ARB_OWNER_IR) ? ir_data_ready : dr_data_ready);
    assign pop            = mem_data_valid && mem_data_ready;

    // Data arriving with nothing outstanding is dropped and flagged until reset.
    always_ff @(posedge clk) begin
        if (!rst)                         protocol_err <= 1'b0;
        else if (mem_data_valid && empty) protocol_err <= 1'b1;
    end

endmodule
